store_commit_drain: RTL and testbench

- Drains retired stores from the store queue head into the L1 data cache, one store per cycle at most.
- Sits between the commit stage, the store queue (it drives the SQ read pointer and pop signals) and the D-cache write port.
- Tracks how many retired stores are still pending and retries a store when the cache reports a miss.
- Retired stores survive pipeline flushes: flush recovery resets the SQ tail only, never this block.

---
 rtl/store_commit_drain_if.sv | 49 ++++
 rtl/store_commit_drain.sv | 78 +++++++
 tb/tb_store_commit_drain.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/store_commit_drain_if.sv
// Store-drain bus: the SQ head read port, the SQ pop and the D-cache write port.
// The master is the drain engine; the slave is the SQ/D-cache side.
interface store_commit_drain_if #(
  parameter int SQ_ENTRY_NUM = 16,
  parameter int COMMIT_WIDTH = 2,
  parameter int BLOCK_ADDR_W = 28,
  parameter int BLOCK_DATA_W = 128,
  parameter int WORD_NUM     = 4,
  parameter int BYTE_NUM     = 4
);
  localparam int PTR_W = $clog2(SQ_ENTRY_NUM);
  localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);

  // SQ head entry, read combinationally at retiredStoreQueuePtr
  logic [BLOCK_ADDR_W-1:0] headAddr;
  logic [BLOCK_DATA_W-1:0] headData;
  logic                    headCondEnabled;
  logic [WORD_NUM-1:0]     headWordWE;
  logic [BYTE_NUM-1:0]     headByteWE;

  // SQ read pointer and pop
  logic [PTR_W-1:0]        retiredStoreQueuePtr;
  logic                    releaseStoreQueueHead;
  logic [CNT_W-1:0]        releaseStoreQueueHeadEntryNum;

  // D-cache write port
  logic                    dcWrReq;
  logic [BLOCK_ADDR_W-1:0] dcWrAddr;
  logic [BLOCK_DATA_W-1:0] dcWrData;
  logic [WORD_NUM-1:0]     dcWrWordWE;
  logic [BYTE_NUM-1:0]     dcWrByteWE;
  logic                    dcWrAck;
  logic                    dcWrNack;
  logic                    dcRefillDone;

  modport master (
    input  headAddr, headData, headCondEnabled, headWordWE, headByteWE,
    input  dcWrAck, dcWrNack, dcRefillDone,
    output retiredStoreQueuePtr, releaseStoreQueueHead, releaseStoreQueueHeadEntryNum,
    output dcWrReq, dcWrAddr, dcWrData, dcWrWordWE, dcWrByteWE
  );

  modport slave (
    output headAddr, headData, headCondEnabled, headWordWE, headByteWE,
    output dcWrAck, dcWrNack, dcRefillDone,
    input  retiredStoreQueuePtr, releaseStoreQueueHead, releaseStoreQueueHeadEntryNum,
    input  dcWrReq, dcWrAddr, dcWrData, dcWrWordWE, dcWrByteWE
  );
endinterface

// File: rtl/store_commit_drain.sv
// Drains retired stores from the SQ head into the D-cache, at most one per cycle.
// Misses park the engine in WAIT_REFILL until the refill completes, then the same
// head is retried, so stores always reach the cache in SQ order.
module store_commit_drain #(
  parameter int SQ_ENTRY_NUM = 16,
  parameter int COMMIT_WIDTH = 2,
  parameter int BLOCK_ADDR_W = 28,
  parameter int BLOCK_DATA_W = 128,
  parameter int WORD_NUM     = 4,
  parameter int BYTE_NUM     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0]    commitStoreNum,
  store_commit_drain_if.master                 bus,
  output logic [$clog2(SQ_ENTRY_NUM+1)-1:0]    pendingCount,
  output logic                                 busy,
  output logic                                 overflowErr
);
  localparam int PTR_W  = $clog2(SQ_ENTRY_NUM);
  localparam int CNT_W  = $clog2(COMMIT_WIDTH + 1);
  localparam int PEND_W = $clog2(SQ_ENTRY_NUM + 1);
  localparam int SUM_W  = PEND_W + 1;

  typedef enum logic {ISSUE, WAIT_REFILL} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic             active;
  logic             issue;
  logic             doRelease;
  logic             miss;
  logic [SUM_W-1:0] sumNext;

  // Head decision: suppressed stores pop without a write; enabled stores pop on ack.
  // An ack alongside a nack wins, since the write was performed.
  always_comb begin
    active    = (state == ISSUE) && (pendingCount != '0);
    issue     = active && bus.headCondEnabled;
    doRelease = active && (!bus.headCondEnabled || bus.dcWrAck);
    miss      = issue && !bus.dcWrAck && bus.dcWrNack;
    sumNext   = SUM_W'(pendingCount) + SUM_W'(commitStoreNum) - SUM_W'(doRelease);
  end

  assign bus.retiredStoreQueuePtr          = ptr;
  assign bus.releaseStoreQueueHead         = doRelease;
  assign bus.releaseStoreQueueHeadEntryNum = CNT_W'(doRelease);
  assign bus.dcWrReq                       = issue;
  assign bus.dcWrAddr                      = bus.headAddr;
  assign bus.dcWrData                      = bus.headData;
  assign bus.dcWrWordWE                    = bus.headWordWE;
  assign bus.dcWrByteWE                    = bus.headByteWE;
  assign busy = (pendingCount != '0) || (state != ISSUE);

  // Drain FSM plus head pointer and pending-store accounting (saturating, sticky overflow).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ISSUE;
      ptr          <= '0;
      pendingCount <= '0;
      overflowErr  <= 1'b0;
    end else begin
      case (state)
        ISSUE:       if (miss) state <= WAIT_REFILL;
        WAIT_REFILL: if (bus.dcRefillDone) state <= ISSUE;
        default:     state <= ISSUE;
      endcase
      if (doRelease)
        ptr <= (ptr == PTR_W'(SQ_ENTRY_NUM - 1)) ? '0 : ptr + PTR_W'(1);
      if (sumNext > SUM_W'(SQ_ENTRY_NUM)) begin
        overflowErr  <= 1'b1;
        pendingCount <= PEND_W'(SQ_ENTRY_NUM);
      end else begin
        pendingCount <= sumNext[PEND_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_store_commit_drain.sv
// Directed + random bench for store_commit_drain. The reference model tracks the
// SQ head index, the count of retired-but-unwritten stores and whether a refill
// is outstanding; the SQ contents live in bench arrays.
module tb_store_commit_drain;
  localparam int SQN = 16, CW = 2, AW = 28, DW = 128, WN = 4, BN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] commitStoreNum = '0;
  logic [4:0] pendingCount;
  logic       busy, overflowErr;

  store_commit_drain_if #(.SQ_ENTRY_NUM(SQN), .COMMIT_WIDTH(CW), .BLOCK_ADDR_W(AW),
                          .BLOCK_DATA_W(DW), .WORD_NUM(WN), .BYTE_NUM(BN)) bus();

  store_commit_drain #(.SQ_ENTRY_NUM(SQN), .COMMIT_WIDTH(CW), .BLOCK_ADDR_W(AW),
                       .BLOCK_DATA_W(DW), .WORD_NUM(WN), .BYTE_NUM(BN)) dut (
    .clk(clk), .rst_n(rst_n), .commitStoreNum(commitStoreNum), .bus(bus),
    .pendingCount(pendingCount), .busy(busy), .overflowErr(overflowErr));

  always #5 clk = ~clk;

  // store queue contents
  logic [AW-1:0] sqAddr [SQN];
  logic [DW-1:0] sqData [SQN];
  logic          sqCond [SQN];
  logic [WN-1:0] sqWWE  [SQN];
  logic [BN-1:0] sqBWE  [SQN];

  assign bus.headAddr        = sqAddr[bus.retiredStoreQueuePtr];
  assign bus.headData        = sqData[bus.retiredStoreQueuePtr];
  assign bus.headCondEnabled = sqCond[bus.retiredStoreQueuePtr];
  assign bus.headWordWE      = sqWWE[bus.retiredStoreQueuePtr];
  assign bus.headByteWE      = sqBWE[bus.retiredStoreQueuePtr];

  int nAsserts = 0, nFail = 0;
  int mPtr = 0, mPend = 0, relCount = 0;
  bit mWait = 0, mOvf = 0;
  logic obsReq, obsRel;
  logic [AW-1:0] obsAddr, savedAddr;
  logic [DW-1:0] obsData, savedData;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randEntry(input int i, input bit allowSuppress);
    sqAddr[i] = AW'($urandom);
    sqData[i] = {$urandom, $urandom, $urandom, $urandom};
    sqCond[i] = allowSuppress ? ($urandom_range(0, 4) != 0) : 1'b1;
    sqWWE[i]  = WN'($urandom);
    sqBWE[i]  = BN'($urandom);
  endtask

  task automatic resetCheck(input string tag);
    chk({tag, "_req"}, bus.dcWrReq, 0);
    chk({tag, "_rel"}, bus.releaseStoreQueueHead, 0);
    chk({tag, "_relNum"}, bus.releaseStoreQueueHeadEntryNum, 0);
    chk({tag, "_ptr"}, bus.retiredStoreQueuePtr, 0);
    chk({tag, "_pend"}, pendingCount, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"}, overflowErr, 0);
  endtask

  // One clock cycle: drive inputs, check same-cycle outputs, advance the model,
  // then check the registered state after the edge. Called at posedge+1.
  task automatic step(input int cn, input bit ack, input bit nack, input bit refill);
    bit act, eReq, eRel;
    int n;
    commitStoreNum   = 2'(cn);
    bus.dcWrAck      = ack;
    bus.dcWrNack     = nack;
    bus.dcRefillDone = refill;
    #3;
    act  = !mWait && (mPend > 0);
    eReq = act && sqCond[mPtr];
    eRel = act && (!sqCond[mPtr] || ack);
    obsReq = bus.dcWrReq; obsRel = bus.releaseStoreQueueHead;
    obsAddr = bus.dcWrAddr; obsData = bus.dcWrData;
    chk("dcWrReq", obsReq, eReq);
    chk("release", obsRel, eRel);
    chk("relNum", bus.releaseStoreQueueHeadEntryNum, eRel ? 1 : 0);
    if (eReq) begin
      chk("dcWrAddr", obsAddr, sqAddr[mPtr]);
      chk("dcWrData", obsData, sqData[mPtr]);
      chk("dcWrWordWE", bus.dcWrWordWE, sqWWE[mPtr]);
      chk("dcWrByteWE", bus.dcWrByteWE, sqBWE[mPtr]);
    end
    if (mWait) begin
      if (refill) mWait = 0;
    end else if (eReq && !ack && nack) begin
      mWait = 1;
    end
    n = mPend + cn - (eRel ? 1 : 0);
    if (n > SQN) begin n = SQN; mOvf = 1; end
    mPend = n;
    if (eRel) begin relCount++; mPtr = (mPtr + 1) % SQN; end
    @(posedge clk); #1;
    chk("ptr", bus.retiredStoreQueuePtr, mPtr);
    chk("pendingCount", pendingCount, mPend);
    chk("busy", busy, (mPend != 0) || mWait);
    chk("overflowErr", overflowErr, mOvf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, cn, oldPtr;
    bit rel;
    for (int i = 0; i < SQN; i++) randEntry(i, 0);
    bus.dcWrAck = 0; bus.dcWrNack = 0; bus.dcRefillDone = 0;
    #12;
    resetCheck("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single hit
    sqAddr[0] = 28'h12; sqWWE[0] = 4'b0001;
    step(1, 1, 0, 0);
    chk("hit_c0_req", obsReq, 0);
    step(0, 1, 0, 0);
    chk("hit_c1_req", obsReq, 1);
    chk("hit_c1_rel", obsRel, 1);
    chk("hit_c1_addr", obsAddr, 28'h12);
    chk("hit_ptr", bus.retiredStoreQueuePtr, 1);
    chk("hit_pend", pendingCount, 0);
    chk("hit_busy", busy, 0);

    // burst with wrap: move the head to 14 first
    repeat (13) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("pre_ptr14", bus.retiredStoreQueuePtr, 14);
    rc = relCount;
    step(2, 1, 0, 0); chk("wrap_ptr_a", bus.retiredStoreQueuePtr, 14);
    step(2, 1, 0, 0); chk("wrap_ptr_b", bus.retiredStoreQueuePtr, 15);
    step(0, 1, 0, 0); chk("wrap_ptr_c", bus.retiredStoreQueuePtr, 0);
    step(0, 1, 0, 0); chk("wrap_ptr_d", bus.retiredStoreQueuePtr, 1);
    step(0, 1, 0, 0); chk("wrap_ptr_e", bus.retiredStoreQueuePtr, 2);
    chk("wrap_rels", relCount - rc, 4);
    chk("wrap_pend", pendingCount, 0);

    // miss and retry
    step(1, 0, 0, 0);
    rc = relCount;
    step(0, 0, 1, 0);
    chk("miss_req", obsReq, 1);
    chk("miss_rel", obsRel, 0);
    savedAddr = obsAddr; savedData = obsData;
    repeat (4) begin
      step(0, 0, 0, 0);
      chk("wait_req", obsReq, 0);
      chk("wait_busy", busy, 1);
    end
    step(0, 0, 0, 1);
    chk("refill_req", obsReq, 0);
    step(0, 1, 0, 0);
    chk("retry_req", obsReq, 1);
    chk("retry_addr", obsAddr, savedAddr);
    chk("retry_data", obsData, savedData);
    chk("retry_rels", relCount - rc, 1);

    // suppressed store
    sqCond[mPtr] = 1'b0;
    oldPtr = mPtr;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("supp_req", obsReq, 0);
    chk("supp_rel", obsRel, 1);
    sqCond[oldPtr] = 1'b1;

    // simultaneous commit and release
    step(2, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("simul_pend3", pendingCount, 3);
    step(2, 1, 0, 0);
    chk("simul_pend4", pendingCount, 4);
    while (mPend > 0) step(0, 1, 0, 0);

    // overflow, then reset with a request in flight
    repeat (9) step(2, 0, 0, 0);
    chk("ovf_flag", overflowErr, 1);
    chk("ovf_pend", pendingCount, 16);
    commitStoreNum = 0;
    #3;
    chk("ovf_req_live", bus.dcWrReq, 1);
    rst_n = 1'b0;
    #1;
    resetCheck("midreset");
    mPtr = 0; mPend = 0; mWait = 0; mOvf = 0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    step(0, 1, 0, 0);
    chk("postreset_req", obsReq, 0);

    // random traffic
    for (int i = 0; i < SQN; i++) randEntry(i, 1);
    repeat (500) begin
      cn = (mPend >= SQN - 2) ? $urandom_range(0, 1) : $urandom_range(0, 2);
      oldPtr = mPtr;
      rc = relCount;
      step(cn, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
           mWait && ($urandom_range(0, 3) == 0));
      rel = (relCount != rc);
      if (rel) randEntry(oldPtr, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end
endmodule
